// File: rtl/rom_fetch.sv
// Byte-serial read front end for a synchronous byte-wide boot ROM.
// Decodes the top-of-space ROM window and assembles 1-4 bytes little-endian.
module rom_fetch #(
    parameter int AW = 18,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req,
    input  logic [23:0]   req_addr,
    input  logic [1:0]    req_len,
    output logic          ready,
    output logic          rsp_valid,
    output logic [31:0]   rsp_data,
    output logic          rsp_err,
    output logic          rom_ce,
    output logic [AW-1:0] rom_address,
    input  logic [DW-1:0] rom_q
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] rom_address_q, rom_address_d;
    logic          rom_ce_q, rom_ce_d;
    logic [1:0]    issue_left_q, issue_left_d;
    logic          cap_en_q, cap_en_d;
    logic [1:0]    cap_cnt_q, cap_cnt_d;
    logic [31:0]   acc_q, acc_d;
    logic          err_q, err_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    logic          in_window;
    logic [31:0]   acc_cap;

    assign in_window = &req_addr[23:AW];

    // cap_en_q marks the cycle where rom_q holds the byte addressed one cycle earlier.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign acc_cap[gi*8 +: 8] = (cap_en_q && (cap_cnt_q == 2'(gi))) ? rom_q : acc_q[gi*8 +: 8];
    end

    always_comb begin
        state_d       = state_q;
        rom_address_d = rom_address_q;
        rom_ce_d      = rom_ce_q;
        issue_left_d  = issue_left_q;
        cap_en_d      = rom_ce_q;
        cap_cnt_d     = cap_en_q ? cap_cnt_q + 2'd1 : cap_cnt_q;
        acc_d         = acc_cap;
        err_d         = err_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    issue_left_d = req_len;
                    acc_d        = '0;
                    cap_cnt_d    = 2'd0;
                    if (in_window) begin
                        state_d       = S_ISSUE;
                        rom_ce_d      = 1'b1;
                        rom_address_d = req_addr[AW-1:0];
                        err_d         = 1'b0;
                    end else begin
                        // Out-of-window: skip the ROM, pass through DRAIN so RESP lands at T+2.
                        state_d = S_DRAIN;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (issue_left_q == 2'd0) begin
                    state_d  = S_DRAIN;
                    rom_ce_d = 1'b0;
                end else begin
                    rom_address_d = rom_address_q + 1'b1;
                    issue_left_d  = issue_left_q - 2'd1;
                end
            end
            S_DRAIN: begin
                state_d    = S_RESP;
                rsp_err_d  = err_q;
                rsp_data_d = err_q ? 32'd0 : acc_cap;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rom_address_q <= '0;
            rom_ce_q      <= 1'b0;
            issue_left_q  <= 2'd0;
            cap_en_q      <= 1'b0;
            cap_cnt_q     <= 2'd0;
            acc_q         <= '0;
            err_q         <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rom_address_q <= rom_address_d;
            rom_ce_q      <= rom_ce_d;
            issue_left_q  <= issue_left_d;
            cap_en_q      <= cap_en_d;
            cap_cnt_q     <= cap_cnt_d;
            acc_q         <= acc_d;
            err_q         <= err_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign rom_ce      = rom_ce_q;
    assign rom_address = rom_address_q;

endmodule

// File: tb/tb_rom_fetch.sv
// Scoreboard bench for rom_fetch: ROM macro model, behavioural reference,
// directed cases followed by randomized traffic.
module tb_rom_fetch;
    localparam int AW = 18;
    localparam logic [23:0] WIN_BASE = 24'((1 << 24) - (1 << AW));

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic [23:0]   req_addr = '0;
    logic [1:0]    req_len = '0;
    logic          ready, rsp_valid, rsp_err, rom_ce;
    logic [31:0]   rsp_data;
    logic [AW-1:0] rom_address;
    logic [7:0]    rom_q = '0;

    rom_fetch #(.AW(AW), .DW(8)) dut (
        .clock(clock), .reset(reset), .req(req), .req_addr(req_addr), .req_len(req_len),
        .ready(ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rom_ce(rom_ce), .rom_address(rom_address), .rom_q(rom_q)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clock) if (rom_ce) rom_q <= mem[rom_address];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          at;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] aq[$];
    int            n_checks = 0;
    int            n_pass = 0;
    logic [31:0]   last_data = '0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: bytes read at consecutive offsets modulo the ROM size, little-endian.
    function automatic logic [31:0] model(input logic [23:0] a, input logic [1:0] l);
        logic [31:0] d = '0;
        if (a < WIN_BASE) return 32'd0;
        for (int k = 0; k <= int'(l); k++)
            d = d | (32'(mem[(int'(a[AW-1:0]) + k) % (1 << AW)]) << (8 * k));
        return d;
    endfunction

    always @(negedge clock) begin : monitor
        exp_t          x;
        logic [AW-1:0] e;
        if (!reset) begin
            if (rom_ce) begin
                if (aq.size() == 0) chk(1'b0, "unexpected_rom_ce", 32'(rom_address), 32'd0);
                else begin
                    e = aq.pop_front();
                    chk(rom_address == e, "rom_address", 32'(rom_address), 32'(e));
                end
            end
            if (rsp_valid) begin
                if (sb.size() == 0) chk(1'b0, "unexpected_rsp", rsp_data, 32'd0);
                else begin
                    x = sb.pop_front();
                    chk(rsp_data == x.data, "rsp_data", rsp_data, x.data);
                    chk(rsp_err == x.err, "rsp_err", 32'(rsp_err), 32'(x.err));
                    chk(cyc == x.at, "rsp_latency", cyc, x.at);
                    $display("rsp cycle=%0d data=0x%08h err=%0d", cyc, rsp_data, rsp_err);
                end
            end
        end
    end

    // Called just after a clock edge; returns just after the accepting edge.
    task automatic send(input logic [23:0] a, input logic [1:0] l, output int acc_cyc);
        int g = 0;
        int n;
        req = 1'b1; req_addr = a; req_len = l;
        while (!ready && g < 100) begin @(posedge clock); #1; g++; end
        if (!ready) begin
            chk(1'b0, "accept_timeout", 32'(g), 32'd0);
            acc_cyc = -1;
            return;
        end
        @(posedge clock); #1;
        acc_cyc = cyc;
        n = int'(l) + 1;
        last_data = model(a, l);
        if (a >= WIN_BASE) begin
            for (int k = 0; k < n; k++) aq.push_back(AW'(int'(a[AW-1:0]) + k));
            sb.push_back('{last_data, 1'b0, cyc + n + 1});
        end else begin
            sb.push_back('{32'd0, 1'b1, cyc + 1});
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        req = 1'b0;
        while (!(sb.size() == 0 && ready) && g < 300) begin @(posedge clock); #1; g++; end
        chk(sb.size() == 0 && ready, "idle_timeout", 32'(sb.size()), 32'd0);
        chk(rsp_data == last_data, "rsp_hold", rsp_data, last_data);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int a1, a2, a0;
        logic [23:0] ra;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk(ready == 1'b1, "reset_ready", 32'(ready), 32'd1);
        chk(rom_ce == 1'b0, "reset_rom_ce", 32'(rom_ce), 32'd0);
        chk(rsp_valid == 1'b0, "reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk(rsp_data == 32'd0, "reset_rsp_data", rsp_data, 32'd0);
        chk(rsp_err == 1'b0, "reset_rsp_err", 32'(rsp_err), 32'd0);
        chk(rom_address == '0, "reset_rom_address", 32'(rom_address), 32'd0);
        @(posedge clock); #1;

        // Out-of-window
        send(24'h000000, 2'd0, a0);
        wait_idle();
        chk(rsp_err == 1'b1, "oow_err", 32'(rsp_err), 32'd1);

        // Top of window, 4 bytes
        mem[18'h3FFFC] = 8'h11; mem[18'h3FFFD] = 8'h22; mem[18'h3FFFE] = 8'h33; mem[18'h3FFFF] = 8'h44;
        send(24'hFFFFFC, 2'd3, a0);
        wait_idle();
        chk(rsp_data == 32'h44332211, "dir_top4", rsp_data, 32'h44332211);

        // Wrap past 0xFFFFFF
        mem[18'h3FFFE] = 8'hAA; mem[18'h3FFFF] = 8'hBB; mem[18'h00000] = 8'hCC; mem[18'h00001] = 8'hDD;
        send(24'hFFFFFE, 2'd3, a0);
        wait_idle();
        chk(rsp_data == 32'hDDCCBBAA, "dir_wrap", rsp_data, 32'hDDCCBBAA);

        // Single byte with ready timing T+1..T+4
        mem[18'h00010] = 8'h5A;
        send(24'hFC0010, 2'd0, a0);
        req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            chk(ready == (k == 4), "single_ready_timing", 32'(ready), 32'(k == 4));
        end
        @(posedge clock); #1;
        wait_idle();
        chk(rsp_data == 32'h0000005A, "dir_single", rsp_data, 32'h0000005A);

        // Back-to-back with req held high
        send(24'hFC1234, 2'd1, a1);
        send(24'hFD0100, 2'd2, a2);
        chk(a2 - a1 == 5, "b2b_spacing", 32'(a2 - a1), 32'd5);
        wait_idle();

        // Pulse while busy must be ignored
        send(24'hFE0040, 2'd3, a0);
        req = 1'b0;
        @(posedge clock); #1;
        req = 1'b1; req_addr = 24'hFC0000; req_len = 2'd0;
        @(posedge clock); #1;
        req = 1'b0;
        wait_idle();
        repeat (10) @(posedge clock); #1;
        chk(sb.size() == 0, "ignored_pulse", 32'(sb.size()), 32'd0);

        // Reset in cycle T+2 of a 4-byte read
        send(24'hFFFFFC, 2'd3, a0);
        req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        aq.delete();
        @(negedge clock);
        chk(rom_ce == 1'b0, "abort_rom_ce", 32'(rom_ce), 32'd0);
        chk(ready == 1'b1, "abort_ready", 32'(ready), 32'd1);
        repeat (10) @(posedge clock); #1;
        send(24'hFC0010, 2'd0, a0);
        wait_idle();
        chk(rsp_data == 32'h0000005A, "post_abort", rsp_data, 32'h0000005A);

        // Randomized traffic, mixing gaps and back-to-back
        for (int i = 0; i < 40; i++) begin
            ra = 24'($urandom);
            if ($urandom_range(0, 2) != 0) ra[23:AW] = '1;
            send(ra, 2'($urandom_range(0, 3)), a0);
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
